// File: rtl/rom_loader_ctrl.sv
// Boot-load controller: parses a framed UART byte stream (A5, LEN, words, CSUM),
// writes little-endian words into the instruction ROM, and holds the CPU until the image verifies.
module rom_loader_ctrl #(
    parameter int          ROM_NUM        = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        load_req_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        wr_en_o,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        cpu_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);
    localparam int WIW = $clog2(ROM_NUM + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t         r_state, w_next;
    logic [15:0]    r_len;
    logic [WIW-1:0] r_word_idx;
    logic [1:0]     r_byte_cnt;
    logic [31:0]    r_word;
    logic [7:0]     r_csum;
    logic [TW-1:0]  r_tmo;
    logic           r_wr_en, r_done;
    logic [31:0]    r_wr_addr, r_wr_data;
    logic [1:0]     r_err_code, w_code;
    logic           w_busy, w_hold, w_err, w_start, w_tmo_hit, w_last, w_len_bad;
    logic [15:0]    w_len_new;
    logic [31:0]    w_word_new;

    assign w_start    = load_req_i && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_tmo_hit  = w_busy && !rx_valid_i && (r_tmo == TMO_LAST);
    assign w_last     = (32'(r_word_idx) + 32'd1 == 32'(r_len));
    assign w_len_new  = {rx_data_i, r_len[7:0]};
    assign w_len_bad  = (w_len_new == 16'd0) || (32'(w_len_new) > 32'(ROM_NUM));
    assign w_word_new = {rx_data_i, r_word[31:8]};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_code = r_err_code;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (load_req_i) w_next = S_SYNC;
            S_SYNC: if (rx_valid_i) begin
                if (rx_data_i == 8'hA5) w_next = S_LEN0;
                else begin w_next = S_ERR; w_code = 2'd0; end
            end
            S_LEN0: if (rx_valid_i) w_next = S_LEN1;
            S_LEN1: if (rx_valid_i) begin
                if (w_len_bad) begin w_next = S_ERR; w_code = 2'd1; end
                else w_next = S_DATA;
            end
            S_DATA: if (rx_valid_i && r_byte_cnt == 2'd3 && w_last) w_next = S_CSUM;
            S_CSUM: if (rx_valid_i) begin
                if (rx_data_i == r_csum) w_next = S_DONE;
                else begin w_next = S_ERR; w_code = 2'd3; end
            end
            default: w_next = S_IDLE;
        endcase
        // a byte in the expiry cycle wins because w_tmo_hit requires !rx_valid_i
        if (w_tmo_hit) begin
            w_next = S_ERR;
            w_code = 2'd2;
        end
    end

    always_comb begin
        w_busy = 1'b0;
        w_hold = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM: begin w_busy = 1'b1; w_hold = 1'b1; end
            S_ERR:   begin w_hold = 1'b1; w_err = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_csum     <= '0;
            r_tmo      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err_code <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= (r_state == S_CSUM) && (w_next == S_DONE);
            if (w_next == S_ERR && r_state != S_ERR) r_err_code <= w_code;
            if (w_start) begin
                r_len      <= '0;
                r_word_idx <= '0;
                r_byte_cnt <= '0;
                r_word     <= '0;
                r_csum     <= '0;
                r_tmo      <= '0;
                r_err_code <= '0;
            end else if (w_busy) begin
                r_tmo <= rx_valid_i ? '0 : r_tmo + 1'b1;
                if (rx_valid_i) begin
                    case (r_state)
                        S_LEN0: r_len[7:0]  <= rx_data_i;
                        S_LEN1: r_len[15:8] <= rx_data_i;
                        S_DATA: begin
                            r_word     <= w_word_new;
                            r_csum     <= r_csum + rx_data_i;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            if (r_byte_cnt == 2'd3) begin
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= BASE_ADDR + (32'(r_word_idx) << 2);
                                r_wr_data  <= w_word_new;
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign wr_en_o    = r_wr_en;
    assign wr_addr_o  = r_wr_addr;
    assign wr_data_o  = r_wr_data;
    assign cpu_hold_o = w_hold;
    assign busy_o     = w_busy;
    assign done_o     = r_done;
    assign err_o      = w_err;
    assign err_code_o = r_err_code;
endmodule
